// File: rtl/fir_array_seq_ctrl.sv
// Frame sequencer for the 16-lane 2D FIR array: coefficient load, then credit-throttled
// data issue, then drain of array results, with done/err reporting.
module fir_array_seq_ctrl #(
  parameter int unsigned LEN_W   = 16,
  parameter int unsigned COEF_W  = 8,
  parameter int unsigned CREDITS = 8,
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [LEN_W-1:0]  frame_len,
  input  logic [COEF_W-1:0] coef_len,
  input  logic              dmac_avail,
  output logic              dmac_rd,
  output logic              valid_dmac,
  output logic              tc_set,
  input  logic              valid_core,
  input  logic              credit_ret,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [LEN_W-1:0]  res_cnt
);

  localparam int unsigned INF_W = $clog2(CREDITS + 1);
  localparam int unsigned TMR_W = $clog2(TIMEOUT + 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_COEF  = 3'd1;
  localparam logic [2:0] S_DATA  = 3'd2;
  localparam logic [2:0] S_DRAIN = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  logic [2:0]        state, state_nx;
  logic [LEN_W-1:0]  flen_q, flen_nx;
  logic [COEF_W-1:0] clen_q, clen_nx;
  logic [COEF_W-1:0] coef_cnt, coef_nx;
  logic [LEN_W-1:0]  dat_cnt, dat_nx;
  logic [INF_W-1:0]  inflight, inf_nx;
  logic [TMR_W-1:0]  timer, tmr_nx;
  logic [LEN_W-1:0]  res_nx;
  logic              err_nx;
  logic              issue;
  logic              count_res;
  logic              data_issue;

  // Issue strobes are decoded straight from state so the DMA pop is zero-latency.
  assign tc_set     = (state == S_COEF);
  assign dmac_rd    = issue;
  assign valid_dmac = issue;
  assign data_issue = issue && (state == S_DATA);

  // Next-state and counter update
  always_comb begin
    state_nx  = state;
    flen_nx   = flen_q;
    clen_nx   = clen_q;
    coef_nx   = coef_cnt;
    dat_nx    = dat_cnt;
    res_nx    = res_cnt;
    err_nx    = err;
    tmr_nx    = '0;
    issue     = 1'b0;
    count_res = 1'b0;

    case (state)
      S_IDLE: begin
        if (start) begin
          flen_nx = frame_len;
          clen_nx = coef_len;
          err_nx  = 1'b0;
          res_nx  = '0;
          coef_nx = '0;
          dat_nx  = '0;
          if (coef_len != '0)       state_nx = S_COEF;
          else if (frame_len != '0) state_nx = S_DATA;
          else                      state_nx = S_DONE;
        end
      end
      S_COEF: begin
        issue = dmac_avail;
        if (issue) begin
          coef_nx = coef_cnt + 1'b1;
          if (coef_nx == clen_q) state_nx = (flen_q != '0) ? S_DATA : S_DONE;
        end
      end
      S_DATA: begin
        issue     = dmac_avail && (inflight < INF_W'(CREDITS));
        count_res = 1'b1;
        if (issue) begin
          dat_nx = dat_cnt + 1'b1;
          if (dat_nx == flen_q) state_nx = S_DRAIN;
        end
      end
      S_DRAIN: begin
        count_res = 1'b1;
        tmr_nx    = valid_core ? '0 : timer + 1'b1;
      end
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase

    // A result beyond the frame length is flagged rather than counted.
    if (count_res && valid_core) begin
      if (res_cnt == flen_q) err_nx = 1'b1;
      else                   res_nx = res_cnt + 1'b1;
    end

    if (state == S_DRAIN) begin
      if (res_nx == flen_q) begin
        state_nx = S_DONE;
      end else if (tmr_nx == TMR_W'(TIMEOUT)) begin
        err_nx   = 1'b1;
        state_nx = S_DONE;
      end
    end
  end

  // Outstanding data beats; a simultaneous issue and credit cancel out.
  always_comb begin
    inf_nx = inflight;
    if (data_issue && !credit_ret)                        inf_nx = inflight + 1'b1;
    else if (!data_issue && credit_ret && inflight != '0) inf_nx = inflight - 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      flen_q   <= '0;
      clen_q   <= '0;
      coef_cnt <= '0;
      dat_cnt  <= '0;
      inflight <= '0;
      timer    <= '0;
      res_cnt  <= '0;
      err      <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state    <= state_nx;
      flen_q   <= flen_nx;
      clen_q   <= clen_nx;
      coef_cnt <= coef_nx;
      dat_cnt  <= dat_nx;
      inflight <= inf_nx;
      timer    <= tmr_nx;
      res_cnt  <= res_nx;
      err      <= err_nx;
      busy     <= (state_nx != S_IDLE);
      done     <= (state_nx == S_DONE);
    end
  end

endmodule

// File: tb/tb_fir_array_seq_ctrl.sv
// Directed bench for fir_array_seq_ctrl: frame-level reference model checked every cycle,
// plus literal expectations per scenario.
module tb_fir_array_seq_ctrl;

  localparam int CREDITS = 8;
  localparam int TIMEOUT = 1024;
  localparam int LAT     = 3;

  localparam int P_IDLE = 0, P_LOAD = 1, P_STREAM = 2, P_WAIT = 3, P_END = 4;

  logic        clk, rst_n, start, dmac_avail, valid_core, credit_ret;
  logic [15:0] frame_len;
  logic [7:0]  coef_len;
  logic        dmac_rd, valid_dmac, tc_set, busy, done, err;
  logic [15:0] res_cnt;

  fir_array_seq_ctrl #(
    .LEN_W(16), .COEF_W(8), .CREDITS(CREDITS), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .frame_len(frame_len), .coef_len(coef_len),
    .dmac_avail(dmac_avail), .dmac_rd(dmac_rd), .valid_dmac(valid_dmac), .tc_set(tc_set),
    .valid_core(valid_core), .credit_ret(credit_ret), .busy(busy), .done(done), .err(err),
    .res_cnt(res_cnt)
  );

  int n_checks = 0;
  int n_err    = 0;
  int cyc      = 0;

  // environment knobs
  int avail_mode  = 0;   // 0: always ready, 1: alternate cycles
  int res_budget  = 0;   // results the array will still return
  int credit_gate = 0;   // credits withheld before this cycle
  int owed        = 0;
  int issue_q[$];

  // observations per frame
  int n_coef_obs, n_dat_obs, n_tc_obs, done_cyc, last_vc, s_cyc;

  // reference model state
  int m_ph, m_coef_left, m_data_left, m_flen, m_res, m_inf, m_idle;
  int m_err;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic clear_obs();
    n_coef_obs = 0; n_dat_obs = 0; n_tc_obs = 0; done_cyc = -1; last_vc = -1;
  endtask

  // Array and output buffer emulation: results LAT cycles after each data beat.
  initial begin
    bit vc, cr;
    forever begin
      @(posedge clk); #1;
      cyc++;
      if (!rst_n) begin
        issue_q.delete();
        owed = 0; valid_core = 1'b0; credit_ret = 1'b0;
        dmac_avail = (avail_mode == 0) ? 1'b1 : cyc[0];
      end else begin
        dmac_avail = (avail_mode == 0) ? 1'b1 : cyc[0];
        vc = 1'b0;
        if (issue_q.size() > 0 && issue_q[0] + LAT <= cyc) begin
          void'(issue_q.pop_front());
          if (res_budget > 0) begin vc = 1'b1; res_budget--; end
        end
        if (cyc >= credit_gate) cr = vc || (owed > 0);
        else                    cr = 1'b0;
        owed = owed + int'(vc) - int'(cr);
        valid_core = vc;
        credit_ret = cr;
      end
    end
  end

  // Reference model and per-cycle compare.
  initial begin
    int e_iss;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        m_ph = P_IDLE; m_res = 0; m_err = 0; m_inf = 0; m_idle = 0;
        m_coef_left = 0; m_data_left = 0; m_flen = 0;
        check("rst_dmac_rd", int'(dmac_rd), 0);
        check("rst_valid_dmac", int'(valid_dmac), 0);
        check("rst_tc_set", int'(tc_set), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_err", int'(err), 0);
        check("rst_res_cnt", int'(res_cnt), 0);
      end else begin
        e_iss = int'(dmac_avail) &
                int'(m_ph == P_LOAD || (m_ph == P_STREAM && m_inf < CREDITS));
        check("dmac_rd", int'(dmac_rd), e_iss);
        check("valid_dmac", int'(valid_dmac), e_iss);
        check("tc_set", int'(tc_set), int'(m_ph == P_LOAD));
        check("busy", int'(busy), int'(m_ph != P_IDLE));
        check("done", int'(done), int'(m_ph == P_END));
        check("err", int'(err), m_err);
        check("res_cnt", int'(res_cnt), m_res);

        if (valid_dmac && tc_set) n_coef_obs++;
        if (valid_dmac && !tc_set) begin n_dat_obs++; issue_q.push_back(cyc); end
        if (tc_set) n_tc_obs++;
        if (valid_core) last_vc = cyc;
        if (done && done_cyc < 0) done_cyc = cyc;

        // model advance to the next cycle
        if (m_ph == P_STREAM && e_iss == 1) begin
          if (!credit_ret) m_inf++;
        end else if (credit_ret && m_inf > 0) begin
          m_inf--;
        end
        if ((m_ph == P_STREAM || m_ph == P_WAIT) && valid_core) begin
          if (m_res == m_flen) m_err = 1;
          else                 m_res++;
        end
        case (m_ph)
          P_IDLE: if (start) begin
            m_flen = int'(frame_len); m_coef_left = int'(coef_len); m_data_left = int'(frame_len);
            m_err = 0; m_res = 0;
            m_ph = (m_coef_left != 0) ? P_LOAD : (m_data_left != 0) ? P_STREAM : P_END;
          end
          P_LOAD: if (e_iss == 1) begin
            m_coef_left--;
            if (m_coef_left == 0) m_ph = (m_data_left != 0) ? P_STREAM : P_END;
          end
          P_STREAM: begin
            m_idle = 0;
            if (e_iss == 1) begin
              m_data_left--;
              if (m_data_left == 0) m_ph = P_WAIT;
            end
          end
          P_WAIT: begin
            m_idle = valid_core ? 0 : m_idle + 1;
            if (m_res == m_flen) m_ph = P_END;
            else if (m_idle == TIMEOUT) begin m_err = 1; m_ph = P_END; end
          end
          default: m_ph = P_IDLE;
        endcase
      end
    end
  end

  task automatic start_frame(input int cl, input int fl);
    @(posedge clk); #2;
    start = 1'b1; coef_len = 8'(cl); frame_len = 16'(fl);
    clear_obs();
    s_cyc = cyc;
    @(posedge clk); #2;
    start = 1'b0;
  endtask

  task automatic wait_done(input int max, input string nm);
    int i;
    i = 0;
    while (done_cyc < 0 && i < max) begin
      @(negedge clk); #1;
      i++;
    end
    check({nm, "_done_seen"}, int'(done_cyc >= 0), 1);
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(posedge clk);
  endtask

  initial begin
    int i;
    rst_n = 1'b0; start = 1'b0; frame_len = '0; coef_len = '0;
    dmac_avail = 1'b0; valid_core = 1'b0; credit_ret = 1'b0;
    clear_obs();
    idle_cycles(3);
    #2 rst_n = 1'b1;
    idle_cycles(2);

    // 9 coefficient beats, 4 data beats, credits echo results; start mid-frame ignored
    avail_mode = 0; credit_gate = 0; res_budget = 4;
    start_frame(9, 4);
    @(posedge clk); #2;
    start = 1'b1; coef_len = 8'd1; frame_len = 16'd1;
    @(posedge clk); #2;
    start = 1'b0;
    wait_done(100, "t1");
    check("t1_tc_cycles", n_tc_obs, 9);
    check("t1_coef_issues", n_coef_obs, 9);
    check("t1_data_issues", n_dat_obs, 4);
    check("t1_done_after_last_vc", done_cyc - last_vc, 1);
    check("t1_done_cycle", done_cyc - s_cyc, 17);
    check("t1_err", int'(err), 0);
    check("t1_res_cnt", int'(res_cnt), 4);
    idle_cycles(10);

    // credit throttling: no credits until 30 cycles after start
    res_budget = 20; credit_gate = 1 << 30;
    start_frame(0, 20);
    credit_gate = s_cyc + 30;
    i = 0;
    while (cyc < s_cyc + 29 && i < 100) begin @(negedge clk); #1; i++; end
    check("t2_issues_before_credit", n_dat_obs, 8);
    wait_done(300, "t2");
    check("t2_data_issues", n_dat_obs, 20);
    check("t2_err", int'(err), 0);
    check("t2_res_cnt", int'(res_cnt), 20);
    credit_gate = 0;
    idle_cycles(20);

    // DMA availability alternating
    avail_mode = 1; res_budget = 5;
    start_frame(3, 5);
    wait_done(100, "t3");
    check("t3_coef_issues", n_coef_obs, 3);
    check("t3_data_issues", n_dat_obs, 5);
    check("t3_err", int'(err), 0);
    check("t3_res_cnt", int'(res_cnt), 5);
    avail_mode = 0;
    idle_cycles(10);

    // missing result: drain timeout
    res_budget = 2;
    start_frame(0, 3);
    wait_done(TIMEOUT + 100, "t4");
    check("t4_err", int'(err), 1);
    check("t4_res_cnt", int'(res_cnt), 2);
    check("t4_idle_span", done_cyc - last_vc, TIMEOUT + 1);
    idle_cycles(5);
    check("t4_err_sticky", int'(err), 1);

    // empty frame; a start during its DONE cycle is ignored
    res_budget = 0;
    start_frame(0, 0);
    start = 1'b1; coef_len = 8'd5; frame_len = 16'd5;
    @(negedge clk); #1;
    check("t5_done_cycle", done_cyc - s_cyc, 1);
    check("t5_err_cleared", int'(err), 0);
    @(posedge clk); #2;
    start = 1'b0;
    @(negedge clk); #1;
    check("t5_busy_ignored_start", int'(busy), 0);
    @(negedge clk); #1;
    check("t5_still_idle", int'(busy), 0);
    check("t5_no_issues", n_dat_obs + n_coef_obs, 0);
    idle_cycles(3);

    // asynchronous reset mid-DATA, then a clean frame
    res_budget = 10;
    start_frame(0, 10);
    i = 0;
    while (n_dat_obs < 5 && i < 50) begin @(negedge clk); #1; i++; end
    check("t6_five_issues", n_dat_obs, 5);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    check("t6_async_dmac_rd", int'(dmac_rd), 0);
    check("t6_async_valid_dmac", int'(valid_dmac), 0);
    check("t6_async_busy", int'(busy), 0);
    check("t6_async_res_cnt", int'(res_cnt), 0);
    idle_cycles(2);
    #2 rst_n = 1'b1;
    idle_cycles(2);
    res_budget = 6;
    start_frame(2, 6);
    wait_done(100, "t6");
    check("t6_coef_issues", n_coef_obs, 2);
    check("t6_data_issues", n_dat_obs, 6);
    check("t6_err", int'(err), 0);
    check("t6_res_cnt", int'(res_cnt), 6);
    idle_cycles(5);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
